// File: rtl/aes_pkg.sv
// Shared AES round-datapath types, constants and byte-level helpers.
// Bytes are column-major: byte k = 4*col + row sits at bits [127-8k -: 8].
package aes_pkg;

    localparam int         NB       = 4;
    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    // Index 0 of an ascending packed range is the most significant element,
    // so block[c] is column c and bytes[k] is byte k in FIPS-197 order.
    typedef word_t [0:NB-1]   block_t;
    typedef byte_t [0:4*NB-1] bytes_t;

    typedef enum logic [1:0] {
        IDLE,
        COL,
        DONE
    } mc_state_e;

    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // Row r of the state is rotated left by r byte positions.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        bytes_t in_b;
        bytes_t out_b;
        in_b = s;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                out_b[4*c + r] = in_b[4*((c + r) % NB) + r];
            end
        end
        return out_b;
    endfunction

endpackage

// File: rtl/mix_column.sv
// Combinational MixColumns on one 32-bit column, row 0 in the top byte.
module mix_column
    import aes_pkg::*;
(
    input  word_t col_in,
    output word_t col_out
);

    byte_t a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_in;

    // 3x is computed as xtime(x) ^ x; each row uses the circulant {2,3,1,1}.
    assign col_out[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign col_out[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign col_out[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign col_out[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/mixcolumns_stage.sv
// AES round stage: ShiftRows at capture, then MixColumns (bypassed in the
// final round) and AddRoundKey one column per cycle through a shared mixer.
module mixcolumns_stage
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] sb,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] state_out,
    output logic         busy,
    output logic         finished
);

    mc_state_e  state_q, state_d;
    logic [1:0] col_q, col_d;
    block_t     shifted_q, shifted_d;
    block_t     out_q, out_d;
    logic       last_q, last_d;
    logic       busy_q, busy_d;
    logic       finished_q, finished_d;

    block_t key_blk;
    word_t  mixed;

    assign key_blk = round_key;

    mix_column u_mix_column (
        .col_in  (shifted_q[col_q]),
        .col_out (mixed)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        col_d      = col_q;
        shifted_d  = shifted_q;
        out_d      = out_q;
        last_d     = last_q;
        busy_d     = 1'b0;
        finished_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shifted_d = shift_rows(sb);
                    last_d    = last_round;
                    col_d     = 2'd0;
                    busy_d    = 1'b1;
                    state_d   = COL;
                end
            end
            COL: begin
                busy_d       = 1'b1;
                out_d[col_q] = (last_q ? shifted_q[col_q] : mixed) ^ key_blk[col_q];
                col_d        = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // finished/busy are registered, so the pulse lands one edge later.
                busy_d     = 1'b1;
                finished_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it only takes effect on a rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_q      <= 2'd0;
            shifted_q  <= '0;
            out_q      <= '0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            state_q    <= state_d;
            col_q      <= col_d;
            shifted_q  <= shifted_d;
            out_q      <= out_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
        end
    end

    assign state_out = out_q;
    assign busy      = busy_q;
    assign finished  = finished_q;

endmodule

// File: tb/tb_mixcolumns_stage.sv
// Self-checking bench for mixcolumns_stage: directed FIPS-197 vectors, protocol
// corner cases and randomized rounds against a matrix-level GF(2^8) model.
module tb_mixcolumns_stage;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] sb;
    logic [127:0] round_key;
    logic         last_round;
    logic [127:0] state_out;
    logic         busy;
    logic         finished;

    int n_vec = 0;
    int n_err = 0;

    mixcolumns_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sb         (sb),
        .round_key  (round_key),
        .last_round (last_round),
        .state_out  (state_out),
        .busy       (busy),
        .finished   (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: GF(2^8) multiply by shift-and-add, MixColumns as a
    // circulant matrix product over the byte-indexed state.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] mix_coef(input int d);
        case (d)
            0:       return 8'd2;
            1:       return 8'd3;
            default: return 8'd1;
        endcase
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s_in,
                                               input logic [127:0] k_in,
                                               input logic         fin);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   acc;
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = s_in[127 - 8*(4*c + r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = s[r][(c + r) % 4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (fin) begin
                    acc = t[r][c];
                end else begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++)
                        acc = acc ^ gmul(mix_coef((k - r + 4) % 4), t[k][c]);
                end
                res[127 - 8*(4*c + r) -: 8] = acc ^ k_in[127 - 8*(4*c + r) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full round from IDLE. Edge k counts from acceptance (k=0). When
    // disturb is set, a second start with foreign data arrives at E2 and in
    // the DONE cycle (edge E5) and must be ignored.
    task automatic run_round(input string tag, input logic [127:0] s_in,
                             input logic [127:0] k_in, input logic fin,
                             input logic [127:0] exp, input logic disturb);
        sb         = s_in;
        round_key  = k_in;
        last_round = fin;
        start      = 1'b1;
        step();
        start      = 1'b0;
        sb         = ~s_in;
        last_round = ~fin;
        check({tag, " busy@E0"}, {127'b0, busy}, 128'd1);
        check({tag, " fin@E0"}, {127'b0, finished}, 128'd0);
        for (int k = 1; k <= 6; k++) begin
            start = disturb && (k == 2 || k == 5);
            step();
            start = 1'b0;
            check($sformatf("%s busy@E%0d", tag, k), {127'b0, busy}, (k <= 5) ? 128'd1 : 128'd0);
            check($sformatf("%s fin@E%0d", tag, k), {127'b0, finished}, (k == 5) ? 128'd1 : 128'd0);
            if (k >= 5) check($sformatf("%s state@E%0d", tag, k), state_out, exp);
        end
        step();
        check({tag, " idle busy"}, {127'b0, busy}, 128'd0);
        check({tag, " idle fin"}, {127'b0, finished}, 128'd0);
    endtask

    localparam logic [127:0] R1_SB  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] R1_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R1_EXP = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] RF_SB  = 128'he9098972cb31075f3d327d94af2e2cb5;
    localparam logic [127:0] RF_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RF_EXP = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        logic [127:0] s_r, k_r, e_r;
        logic         f_r;
        logic [127:0] bb_exp [4];

        rst_n      = 1'b0;
        start      = 1'b0;
        sb         = '0;
        round_key  = '0;
        last_round = 1'b0;
        repeat (3) step();
        check("reset state_out", state_out, 128'd0);
        check("reset busy", {127'b0, busy}, 128'd0);
        check("reset fin", {127'b0, finished}, 128'd0);
        rst_n = 1'b1;
        step();

        run_round("fips_r1", R1_SB, R1_KEY, 1'b0, R1_EXP, 1'b0);
        run_round("fips_final", RF_SB, RF_KEY, 1'b1, RF_EXP, 1'b0);
        // Every column equal means ShiftRows leaves each column unchanged.
        run_round("mixcol_db", {4{32'hdb135345}}, 128'd0, 1'b0, {4{32'h8e4da1bc}}, 1'b0);
        run_round("mixcol_c6", {4{32'hc6c6c6c6}}, 128'd0, 1'b0, {4{32'hc6c6c6c6}}, 1'b0);
        run_round("busy_proto", R1_SB, R1_KEY, 1'b0, R1_EXP, 1'b1);

        // Abort a round with reset sampled at E3.
        sb        = RF_SB;
        round_key = RF_KEY;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst state_out", state_out, 128'd0);
        check("midrst busy", {127'b0, busy}, 128'd0);
        check("midrst fin", {127'b0, finished}, 128'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("midrst nofin %0d", k), {127'b0, finished}, 128'd0);
        end
        run_round("after_rst", R1_SB, R1_KEY, 1'b0, R1_EXP, 1'b0);

        // Back-to-back with start held high: a new acceptance every 6 edges.
        start = 1'b1;
        for (int n = 0; n < 4; n++) begin
            sb         = rand128();
            round_key  = rand128();
            last_round = $urandom_range(0, 1) == 1;
            bb_exp[n]  = ref_round(sb, round_key, last_round);
            for (int k = 0; k <= 5; k++) begin
                step();
                if (k == 1) sb = rand128();
                check($sformatf("b2b r%0d fin@E%0d", n, k), {127'b0, finished}, (k == 5) ? 128'd1 : 128'd0);
                check($sformatf("b2b r%0d busy@E%0d", n, k), {127'b0, busy}, 128'd1);
                if (k == 5) check($sformatf("b2b r%0d state", n), state_out, bb_exp[n]);
            end
        end
        start = 1'b0;
        step();
        check("b2b tail busy", {127'b0, busy}, 128'd0);
        check("b2b tail fin", {127'b0, finished}, 128'd0);

        for (int n = 0; n < 20; n++) begin
            s_r = rand128();
            k_r = rand128();
            f_r = $urandom_range(0, 3) == 0;
            e_r = ref_round(s_r, k_r, f_r);
            run_round($sformatf("rand%0d", n), s_r, k_r, f_r, e_r, $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mixcolumns_stage.md
# mixcolumns_stage

Round-datapath stage directly downstream of `subbytes` in the AES engine. It captures the 128-bit SubBytes result, applies ShiftRows, then MixColumns (skipped in the final round) and AddRoundKey one column per cycle. It signals completion with a one-cycle `finished` pulse, so the round controller can feed the result back to `subbytes` or out as ciphertext.

## Interface
- No parameters. Block size is fixed at 128 bits, Nb = 4.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `sb`  in  128  SubBytes output; byte 0 (row 0, col 0) is `[127:120]`; column-major per FIPS-197
- `round_key`  in  128  round key, same byte order; must be stable from `start` until `finished`
- `last_round`  in  1  sampled with `start`; 1 = bypass MixColumns
- `state_out`  out  128  round result; held until the next accepted `start`
- `busy`  out  1  high from the cycle after acceptance until `finished`, inclusive
- `finished`  out  1  single-cycle pulse; `state_out` is valid in the same cycle

## Operation
- FSM states: IDLE, COL, DONE.
- IDLE, `start`=1:
  - load `shifted` ← ShiftRows(`sb`): row r rotated left by r bytes.
  - latch `last_round`.
  - `col` ← 0.
  - go to COL.
- IDLE, `start`=0: hold all state.
- COL, each cycle:
  - `state_out` column `col` ← MixColumn(`shifted` column `col`) XOR `round_key` column `col`.
  - When `last_round`=1, the MixColumn step is identity.
  - `col` increments. When `col`=3, go to DONE.
- DONE: `finished`=1 for exactly one cycle, then go to IDLE.
- MixColumn arithmetic is GF(2^8) with reduction polynomial 0x11B:
  - out0 = 2a0 ^ 3a1 ^ a2 ^ a3, with remaining rows rotated accordingly.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
- `start` while `busy`: ignored, no queuing. `sb` changes while busy have no effect because the input is captured at acceptance.
- `start` in the DONE cycle is ignored. `start` in the first IDLE cycle after DONE is accepted, giving back-to-back rounds every 6 cycles.
- Columns not yet written during COL hold their previous values. Consumers may use `state_out` only on `finished`.

## Timing
- Reset (`rst_n`=0 at a clock edge) forces:
  - FSM = IDLE, `col` = 0
  - `state_out` = 128'h0, `shifted` = 0
  - `busy` = 0, `finished` = 0
- Reset mid-operation aborts the round with no `finished` pulse. A `start` held across reset release is accepted at the first edge with `rst_n`=1.
- Latency:
  - `start` sampled at edge E0.
  - Columns 0..3 are written at E1..E4.
  - `finished` and `busy` are registered outputs. `finished` is high in the cycle following E5 (5 edges after acceptance), and `busy` falls at the same edge that lowers `finished`.
- `round_key` is sampled per column at E1..E4 and is not captured at `start`.

## Structure
- `aes_pkg`:
  - `NB` = 4
  - `AES_POLY` = 8'h1B
  - `typedef logic [7:0] byte_t`
  - `typedef logic [31:0] word_t`
  - function `xtime`
  - function `shift_rows(logic [127:0])`
  - FSM enum `mc_state_e` {IDLE, COL, DONE}
- Sub-module `mix_column`: purely combinational, 32-bit in, 32-bit out. Instantiate once; a mux selects the column by `col`.
- `mixcolumns_stage` holds the FSM, the 2-bit column counter, the `shifted` register, and the `state_out` register with per-column write enables.

## Test plan
- FIPS-197 App. B round 1:
  - Stimulus: `sb`=d42711aee0bf98f1b8b45de51e415230, `round_key`=a0fafe1788542cb123a339392a6c7605, `last_round`=0.
  - Required: `state_out`=a49c7ff2689f352b6b5bea43026a5049 with `finished` 5 cycles after acceptance, and `busy` high throughout.
- Final round:
  - Stimulus: `sb`=e90989 72cb31075f3d327d94af2e2cb5, `round_key`=d014f9a8c9ee2589e13f0cc8b6630ca6, `last_round`=1.
  - Required: `state_out`=3925841d02dc09fbdc118597196a0b32.
- MixColumn unit:
  - Stimulus: column db135345 with zero key.
  - Required: 8e4da1bc. Also c6c6c6c6 → c6c6c6c6.
- Busy protocol:
  - Stimulus: second `start` with a different `sb` asserted at E2 and in the DONE cycle.
  - Required: both ignored; the result equals round-1 vector; exactly one `finished` pulse.
- Reset mid-round:
  - Stimulus: `rst_n`=0 at E3.
  - Required: next cycle `state_out`=0, `busy`=0, no `finished`. A subsequent full round produces the correct vector.
- Back-to-back:
  - Stimulus: `start` held high continuously.
  - Required: `finished` pulses every 6 cycles and `state_out` updates per round.
